cache_tag_ctrl: RTL and testbench

- Tag/valid lookup and miss-refill controller for the 2-way set-associative L1 cache.
- Accepts one address request at a time and compares tags for both ways of the indexed set.
- Produces the hit/miss, way-hit and per-way valid signals consumed by the cache replacement selector. Samples that selector's victim way on a miss.
- Runs the refill handshake toward the memory side and installs the new tag. Also provides a whole-cache invalidate (flush) walk.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_tag_ctrl_if.sv | 45 ++++
 rtl/cache_tag_array.sv | 52 +++++
 rtl/cache_tag_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the 2-way L1 tag controller.
package cache_pkg;

    localparam int WAYS      = 2;
    localparam int MAX_TAG_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        FLUSH
    } state_t;

    // Tag field is sized for the widest supported tag; narrower tags are zero-extended.
    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
    } tag_entry_t;

    function automatic int offset_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
        return addr_w - index_w(sets) - offset_w(line_bytes);
    endfunction

endpackage

// File: rtl/cache_tag_ctrl_if.sv
// Request, lookup, refill and flush signals between the tag controller and its neighbours.
interface cache_tag_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 128
);
    import cache_pkg::*;

    localparam int INDEX_W = index_w(SETS);

    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_hit_o;
    logic              rsp_way_o;
    logic [INDEX_W-1:0] set_index_o;
    logic              way0_valid_o;
    logic              way1_valid_o;
    logic              hit_o;
    logic              miss_o;
    logic              way_hit_o;
    logic              victim_way_i;
    logic              refill_req_o;
    logic [ADDR_W-1:0] refill_addr_o;
    logic              refill_way_o;
    logic              refill_ack_i;
    logic              flush_i;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;

    modport slave (
        input  req_valid_i, req_addr_i, victim_way_i, refill_ack_i, flush_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, set_index_o,
               way0_valid_o, way1_valid_o, hit_o, miss_o, way_hit_o,
               refill_req_o, refill_addr_o, refill_way_o, hit_cnt_o, miss_cnt_o
    );

    modport master (
        output req_valid_i, req_addr_i, victim_way_i, refill_ack_i, flush_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, set_index_o,
               way0_valid_o, way1_valid_o, hit_o, miss_o, way_hit_o,
               refill_req_o, refill_addr_o, refill_way_o, hit_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/cache_tag_array.sv
// Tag and valid storage for both ways: combinational read, single-way write, per-set clear.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter  int SETS    = 128,
    parameter  int TAG_W   = 20,
    localparam int INDEX_W = index_w(SETS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [INDEX_W-1:0] rd_index,
    output tag_entry_t         rd_entry [WAYS],
    input  logic               wr_en,
    input  logic               wr_way,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_index
);

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [TAG_W-1:0] tag_mem [SETS];
            logic [SETS-1:0]  valid_reg;
            logic             way_sel;

            assign way_sel = (int'(wr_way) == gi);

            // Tags carry no reset; a cleared valid bit makes stale contents harmless.
            always_ff @(posedge clk_i) begin
                if (wr_en && way_sel) begin
                    tag_mem[wr_index] <= wr_tag;
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_reg <= '0;
                end else if (clr_en) begin
                    valid_reg[clr_index] <= 1'b0;
                end else if (wr_en && way_sel) begin
                    valid_reg[wr_index] <= 1'b1;
                end
            end

            assign rd_entry[gi] = '{valid: valid_reg[rd_index],
                                    tag:   MAX_TAG_W'(tag_mem[rd_index])};
        end
    endgenerate

endmodule

// File: rtl/cache_tag_ctrl.sv
// 2-way set-associative tag lookup / refill / flush controller.
// Optional hit and miss counters are built when CACHE_STATS_EN is defined.
module cache_tag_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 128,
    parameter int LINE_BYTES = 32
) (
    input logic              clk_i,
    input logic              rst_ni,
    cache_tag_ctrl_if.slave  bus
);

    localparam int OFFSET_W = offset_w(LINE_BYTES);
    localparam int INDEX_W  = index_w(SETS);
    localparam int TAG_W    = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int LINE_W   = ADDR_W - OFFSET_W;

    state_t             state_reg, state_next;
    logic [LINE_W-1:0]  line_reg;
    logic               victim_reg;
    logic               flush_pend_reg, flush_pend_next;
    logic [INDEX_W-1:0] walk_reg, walk_next;

    logic               latch_addr;
    logic               latch_victim;
    logic               req_ready;
    logic               wr_en;
    logic               clr_en;
    logic               hit_pulse;
    logic               miss_pulse;
    logic               rsp_valid;
    logic               rsp_hit;
    logic               rsp_way;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    tag_entry_t         rd_entry [WAYS];
    logic [WAYS-1:0]    way_match;
    logic               lookup_hit;
    logic               hit_way;

    assign req_index = line_reg[INDEX_W-1:0];
    assign req_tag   = line_reg[LINE_W-1:INDEX_W];

    cache_tag_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_tag_array (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rd_index  (req_index),
        .rd_entry  (rd_entry),
        .wr_en     (wr_en),
        .wr_way    (victim_reg),
        .wr_index  (req_index),
        .wr_tag    (req_tag),
        .clr_en    (clr_en),
        .clr_index (walk_reg)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_match
            assign way_match[gi] = rd_entry[gi].valid && (rd_entry[gi].tag == MAX_TAG_W'(req_tag));
        end
    endgenerate

    assign lookup_hit = |way_match;
    // A double match should never happen; way 0 wins if it does.
    assign hit_way    = !way_match[0];

    always_comb begin
        state_next      = state_reg;
        flush_pend_next = flush_pend_reg;
        walk_next       = walk_reg;
        latch_addr      = 1'b0;
        latch_victim    = 1'b0;
        wr_en           = 1'b0;
        clr_en          = 1'b0;
        hit_pulse       = 1'b0;
        miss_pulse      = 1'b0;
        rsp_valid       = 1'b0;
        rsp_hit         = 1'b0;
        rsp_way         = 1'b0;
        req_ready       = (state_reg == IDLE) && !flush_pend_reg && !bus.flush_i;

        case (state_reg)
            IDLE: begin
                if (bus.flush_i || flush_pend_reg) begin
                    state_next      = FLUSH;
                    walk_next       = '0;
                    flush_pend_next = 1'b0;
                end else if (bus.req_valid_i) begin
                    latch_addr = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.flush_i) flush_pend_next = 1'b1;
                if (lookup_hit) begin
                    hit_pulse  = 1'b1;
                    rsp_valid  = 1'b1;
                    rsp_hit    = 1'b1;
                    rsp_way    = hit_way;
                    state_next = IDLE;
                end else begin
                    miss_pulse   = 1'b1;
                    latch_victim = 1'b1;
                    state_next   = REFILL;
                end
            end
            REFILL: begin
                if (bus.flush_i) flush_pend_next = 1'b1;
                if (bus.refill_ack_i) begin
                    wr_en      = 1'b1;
                    rsp_valid  = 1'b1;
                    rsp_way    = victim_reg;
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                clr_en    = 1'b1;
                walk_next = walk_reg + 1'b1;
                if (walk_reg == INDEX_W'(SETS - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            line_reg       <= '0;
            victim_reg     <= 1'b0;
            flush_pend_reg <= 1'b0;
            walk_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            flush_pend_reg <= flush_pend_next;
            walk_reg       <= walk_next;
            if (latch_addr)   line_reg   <= bus.req_addr_i[ADDR_W-1:OFFSET_W];
            if (latch_victim) victim_reg <= bus.victim_way_i;
        end
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_hit_o     = rsp_hit;
    assign bus.rsp_way_o     = rsp_way;
    assign bus.set_index_o   = req_index;
    assign bus.way0_valid_o  = rd_entry[0].valid;
    assign bus.way1_valid_o  = rd_entry[1].valid;
    assign bus.hit_o         = hit_pulse;
    assign bus.miss_o        = miss_pulse;
    assign bus.way_hit_o     = hit_pulse & hit_way;
    assign bus.refill_req_o  = (state_reg == REFILL);
    assign bus.refill_addr_o = {line_reg, {OFFSET_W{1'b0}}};
    assign bus.refill_way_o  = victim_reg;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else begin
            if (hit_pulse && hit_cnt_reg != 32'hFFFF_FFFF)   hit_cnt_reg  <= hit_cnt_reg + 32'd1;
            if (miss_pulse && miss_cnt_reg != 32'hFFFF_FFFF) miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_reg;
    assign bus.miss_cnt_o = miss_cnt_reg;
`else
    assign bus.hit_cnt_o  = 32'd0;
    assign bus.miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: directed scenarios plus random traffic
// checked against a per-set/per-way tag model.
module tb_cache_tag_ctrl;

    localparam int ADDR_W     = 32;
    localparam int SETS       = 128;
    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = 7;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    cache_tag_ctrl_if #(.ADDR_W(ADDR_W), .SETS(SETS)) bus ();

    cache_tag_ctrl #(
        .ADDR_W     (ADDR_W),
        .SETS       (SETS),
        .LINE_BYTES (LINE_BYTES)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: what each (set, way) currently holds.
    bit          mdl_valid [SETS][2];
    logic [19:0] mdl_tag   [SETS][2];
    int          exp_hits   = 0;
    int          exp_misses = 0;

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            mdl_valid[s][0] = 1'b0;
            mdl_valid[s][1] = 1'b0;
        end
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        check("hit_cnt", bus.hit_cnt_o, exp_hits);
        check("miss_cnt", bus.miss_cnt_o, exp_misses);
`else
        check("hit_cnt_tied", bus.hit_cnt_o, 32'd0);
        check("miss_cnt_tied", bus.miss_cnt_o, 32'd0);
`endif
    endtask

    // Counts consecutive sampled cycles with req_ready_o low and compares to the expected length.
    task automatic wait_flush(input int expected_low);
        int n = 0;
        while (!bus.req_ready_o && n < 1000) begin
            n++;
            tick();
        end
        check("flush_ready_low_cycles", n, expected_low);
        model_clear();
    endtask

    task automatic do_req(input logic [31:0] addr, input bit victim, input int ack_delay,
                          input bit hold, input bit abort_refill);
        int          set_i;
        logic [19:0] tg;
        bit          exp_hit;
        bit          exp_way;
        int          n;

        set_i   = int'((addr >> OFFSET_W) % SETS);
        tg      = addr[31:12];
        exp_hit = 1'b0;
        exp_way = 1'b0;
        for (int w = 1; w >= 0; w--) begin
            if (mdl_valid[set_i][w] && mdl_tag[set_i][w] == tg) begin
                exp_hit = 1'b1;
                exp_way = w[0];
            end
        end

        bus.req_addr_i  = addr;
        bus.req_valid_i = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready_o && n < 1000) begin
            n++;
            tick();
        end
        check("req_ready", bus.req_ready_o, 1'b1);
        tick();
        if (!hold) bus.req_valid_i = 1'b0;
        bus.victim_way_i = victim;
        #1;

        $display("req addr=0x%08h set=%0d expect_%s way=%0d", addr, set_i, exp_hit ? "hit" : "miss",
                 exp_hit ? exp_way : victim);
        check("lookup_set_index", bus.set_index_o, set_i);
        check("lookup_way0_valid", bus.way0_valid_o, mdl_valid[set_i][0]);
        check("lookup_way1_valid", bus.way1_valid_o, mdl_valid[set_i][1]);
        check("lookup_hit", bus.hit_o, exp_hit);
        check("lookup_miss", bus.miss_o, !exp_hit);
        check("lookup_rsp_valid", bus.rsp_valid_o, exp_hit);
        check("lookup_refill_req", bus.refill_req_o, 1'b0);

        if (exp_hit) begin
            check("hit_rsp_hit", bus.rsp_hit_o, 1'b1);
            check("hit_rsp_way", bus.rsp_way_o, exp_way);
            check("hit_way_hit", bus.way_hit_o, exp_way);
            exp_hits++;
            tick();
            check("post_hit_rsp_valid", bus.rsp_valid_o, 1'b0);
            return;
        end

        exp_misses++;
        tick();
        bus.victim_way_i = 1'($urandom);
        #1;
        check("refill_req", bus.refill_req_o, 1'b1);
        check("refill_addr", bus.refill_addr_o, addr & ~32'h1F);
        check("refill_way", bus.refill_way_o, victim);
        check("refill_no_hit", bus.hit_o, 1'b0);
        check("refill_no_miss", bus.miss_o, 1'b0);

        if (abort_refill) begin
            rst_ni = 1'b0;
            #1;
            check("abort_refill_req", bus.refill_req_o, 1'b0);
            check("abort_rsp_valid", bus.rsp_valid_o, 1'b0);
            tick();
            rst_ni = 1'b1;
            model_clear();
            exp_hits   = 0;
            exp_misses = 0;
            return;
        end

        if (hold) begin
            bus.flush_i = 1'b1;
            tick();
            bus.flush_i = 1'b0;
            #1;
            check("refill_held_over_flush", bus.refill_req_o, 1'b1);
        end

        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check("refill_wait_req", bus.refill_req_o, 1'b1);
            check("refill_wait_rsp", bus.rsp_valid_o, 1'b0);
        end

        bus.refill_ack_i = 1'b1;
        #1;
        check("fill_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("fill_rsp_hit", bus.rsp_hit_o, 1'b0);
        check("fill_rsp_way", bus.rsp_way_o, victim);
        tick();
        bus.refill_ack_i = 1'b0;
        #1;
        check("post_fill_refill_req", bus.refill_req_o, 1'b0);
        check("post_fill_rsp_valid", bus.rsp_valid_o, 1'b0);
        mdl_valid[set_i][victim] = 1'b1;
        mdl_tag[set_i][victim]   = tg;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.victim_way_i = 1'b0;
        bus.refill_ack_i = 1'b0;
        bus.flush_i      = 1'b0;
        model_clear();

        #12;
        check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("rst_hit", bus.hit_o, 1'b0);
        check("rst_miss", bus.miss_o, 1'b0);
        check("rst_refill_req", bus.refill_req_o, 1'b0);
        check("rst_refill_addr", bus.refill_addr_o, 32'd0);
        check("rst_set_index", bus.set_index_o, 32'd0);
        check("rst_way0_valid", bus.way0_valid_o, 1'b0);
        check_stats();
        tick();
        rst_ni = 1'b1;
        tick();

        // Basic fill / hit / eviction sequence on set 2.
        do_req(32'h0000_1040, 1'b0, 3, 1'b0, 1'b0);
        do_req(32'h0000_1044, 1'b1, 0, 1'b0, 1'b0);
        do_req(32'h0000_2040, 1'b1, 1, 1'b0, 1'b0);
        do_req(32'h0000_3040, 1'b0, 2, 1'b0, 1'b0);
        do_req(32'h0000_1040, 1'b0, 0, 1'b0, 1'b0);
        do_req(32'h0000_2040, 1'b0, 0, 1'b0, 1'b0);
        check_stats();

        // Flush from IDLE.
        bus.flush_i = 1'b1;
        #1;
        check("flush_ready_drop", bus.req_ready_o, 1'b0);
        tick();
        bus.flush_i = 1'b0;
        wait_flush(SETS);
        do_req(32'h0000_2040, 1'b1, 1, 1'b0, 1'b0);

        // Flush pulsed during refill with the next request held valid.
        do_req(32'h0000_5080, 1'b1, 2, 1'b1, 1'b0);
        wait_flush(SETS + 1);
        do_req(32'h0000_5080, 1'b0, 1, 1'b0, 1'b0);
        check_stats();

        // Random traffic over a small set/tag pool so hits and evictions are frequent.
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            a = ({28'd0, 4'($urandom_range(0, 3))} << 12)
              | ({30'd0, 2'($urandom_range(0, 3))} << OFFSET_W)
              | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) begin
                bus.flush_i = 1'b1;
                tick();
                bus.flush_i = 1'b0;
                wait_flush(SETS);
            end
            do_req(a, 1'($urandom), $urandom_range(0, 3), 1'b0, 1'b0);
        end
        check_stats();

        // Reset in the middle of a refill abandons it and clears everything.
        do_req(32'h0000_1040, 1'b0, 0, 1'b0, 1'b0);
        do_req(32'h0000_1040, 1'b1, 0, 1'b0, 1'b0);
        do_req(32'h0000_7040, 1'b1, 1, 1'b0, 1'b1);
        check_stats();
        do_req(32'h0000_1040, 1'b1, 0, 1'b0, 1'b0);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
